// File: rtl/iir_sample_capture.sv
// rtl/iir_sample_capture.sv - IIR output sample capture with settle skip, capture window and FWFT FIFO
module iir_sample_capture #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int DIV    = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        y_in,
   input  logic                     arm,
   input  logic                     stop,
   input  logic [7:0]               skip,
   input  logic [7:0]               count,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [DW-1:0]       div_q, div_d;
   logic [7:0]          skip_cnt_q, skip_cnt_d;
   logic [7:0]          cap_cnt_q, cap_cnt_d;
   logic                done_q, done_d;
   logic                overflow_q, overflow_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       level_q, level_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                busy_w;
   logic                tick;
   logic                rd_en;
   logic                has_room;
   logic                wr_en;

   always_comb begin
      busy_w   = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
      tick     = busy_w && (div_q == DW'(DIV - 1));
      rd_en    = (level_q != '0) && out_ready;
      // A simultaneous read frees the slot, so a full FIFO still accepts the write.
      has_room = (level_q < LW'(DEPTH)) || rd_en;
      wr_en    = (state_q == S_CAPTURE) && tick && !stop && has_room;
   end

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      skip_cnt_d = skip_cnt_q;
      cap_cnt_d  = cap_cnt_q;
      done_d     = done_q;
      overflow_d = overflow_q;

      if (busy_w) begin
         div_d = tick ? '0 : div_q + DW'(1);
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm) begin
               skip_cnt_d = skip;
               cap_cnt_d  = count;
               div_d      = '0;
               done_d     = 1'b0;
               overflow_d = 1'b0;
               state_d    = (skip != 8'd0) ? S_SETTLE : S_CAPTURE;
            end
         end
         S_SETTLE: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (tick) begin
               skip_cnt_d = skip_cnt_q - 8'd1;
               if (skip_cnt_q == 8'd1) begin
                  state_d = S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (tick) begin
               if (!has_room) begin
                  overflow_d = 1'b1;
               end
               // A zero capture counter in CAPTURE means a continuous run.
               if (cap_cnt_q != 8'd0) begin
                  cap_cnt_d = cap_cnt_q - 8'd1;
                  if (cap_cnt_q == 8'd1) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      level_d = level_q + LW'(wr_en) - LW'(rd_en);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         skip_cnt_q <= '0;
         cap_cnt_q  <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         skip_cnt_q <= skip_cnt_d;
         cap_cnt_q  <= cap_cnt_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && wr_en) begin
         mem_q[wr_ptr_q] <= y_in;
      end
   end

   assign out_valid = (level_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign busy      = busy_w;
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign level     = level_q;

endmodule

// File: tb/tb_iir_sample_capture.sv
// tb/tb_iir_sample_capture.sv - directed self-checking bench for iir_sample_capture
module tb_iir_sample_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] y_in;
   logic        arm;
   logic        stop;
   logic [7:0]  skip;
   logic [7:0]  count;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [4:0]  level;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] rx [$];

   iir_sample_capture #(.DATA_W(16), .DEPTH(16), .DIV(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .y_in      (y_in),
      .arm       (arm),
      .stop      (stop),
      .skip      (skip),
      .count     (count),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .level     (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sink snapshot at the falling edge, then advance past the rising edge.
   task automatic cyc();
      @(negedge clk);
      if (out_valid && out_ready) rx.push_back(out_data);
      @(posedge clk);
      #1;
   endtask

   // Edge n after the arm edge carries y = base + (n-1)/2, so tick k sees base + k.
   task automatic run(input int n_from, input int n_to, input logic [15:0] base);
      for (int n = n_from; n <= n_to; n++) begin
         y_in = base + 16'((n - 1) / 2);
         cyc();
      end
   endtask

   task automatic do_arm(input logic [7:0] s, input logic [7:0] c);
      skip = s;
      count = c;
      arm = 1'b1;
      cyc();
      arm = 1'b0;
   endtask

   task automatic check_rx(input string tag, input logic [15:0] base, input int n);
      logic [15:0] got;
      chk($sformatf("%s_n", tag), rx.size(), n);
      for (int i = 0; i < n; i++) begin
         got = (i < rx.size()) ? rx[i] : 16'hxxxx;
         chk($sformatf("%s_%0d", tag, i), got, base + 16'(i));
      end
      rx.delete();
   endtask

   initial begin
      int busy_bad;
      reset = 1'b0;
      arm = 1'b1;
      stop = 1'b0;
      skip = 8'd0;
      count = 8'd0;
      y_in = 16'h0000;
      out_ready = 1'b1;

      // Reset beats arm
      cyc();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_level", level, 0);
      reset = 1'b1;
      arm = 1'b0;
      cyc();
      chk("rst_idle_busy", busy, 0);
      chk("rst_idle_level", level, 0);
      rx.delete();

      // Counted run: skip 3, capture 4
      out_ready = 1'b1;
      do_arm(8'd3, 8'd4);
      chk("cnt_busy_rise", busy, 1);
      run(1, 13, 16'h0100);
      chk("cnt_busy_e13", busy, 1);
      chk("cnt_done_e13", done, 0);
      run(14, 14, 16'h0100);
      chk("cnt_done", done, 1);
      chk("cnt_busy_fall", busy, 0);
      run(15, 17, 16'h0100);
      chk("cnt_ovf", overflow, 0);
      check_rx("cnt_rx", 16'h0103, 4);

      // Overflow: 20 ticks into 16 entries, no reads
      out_ready = 1'b0;
      do_arm(8'd0, 8'd20);
      chk("ovf_busy", busy, 1);
      chk("ovf_done_clr", done, 0);
      run(1, 32, 16'h0200);
      chk("ovf_full_level", level, 16);
      chk("ovf_not_yet", overflow, 0);
      run(33, 40, 16'h0200);
      chk("ovf_level_sat", level, 16);
      chk("ovf_flag", overflow, 1);
      chk("ovf_done", done, 1);
      chk("ovf_busy_fall", busy, 0);
      out_ready = 1'b1;
      run(41, 60, 16'h0200);
      chk("ovf_drained", level, 0);
      chk("ovf_valid_low", out_valid, 0);
      check_rx("ovf_rx", 16'h0200, 16);

      // Full FIFO with a read on the tick edge
      out_ready = 1'b0;
      do_arm(8'd0, 8'd0);
      chk("full_ovf_clr", overflow, 0);
      run(1, 33, 16'h0300);
      chk("full_level", level, 16);
      out_ready = 1'b1;
      run(34, 34, 16'h0300);
      chk("full_rw_level", level, 16);
      chk("full_rw_ovf", overflow, 0);
      out_ready = 1'b0;
      stop = 1'b1;
      run(35, 35, 16'h0300);
      stop = 1'b0;
      chk("full_stop_busy", busy, 0);
      chk("full_stop_level", level, 16);
      out_ready = 1'b1;
      run(36, 55, 16'h0300);
      check_rx("full_rx", 16'h0300, 17);

      // Stop after 5 captured ticks, landing on a tick edge
      out_ready = 1'b0;
      do_arm(8'd0, 8'd0);
      run(1, 11, 16'h0400);
      chk("stop_level5", level, 5);
      stop = 1'b1;
      run(12, 12, 16'h0400);
      stop = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      chk("stop_level", level, 5);
      run(13, 16, 16'h0400);
      chk("stop_idle_level", level, 5);
      out_ready = 1'b1;
      run(17, 24, 16'h0400);
      check_rx("stop_rx", 16'h0400, 5);

      // Re-arm after stop: skip 2, capture 1
      out_ready = 1'b0;
      do_arm(8'd2, 8'd1);
      chk("rearm_busy", busy, 1);
      run(1, 5, 16'h0500);
      chk("rearm_level_e5", level, 0);
      run(6, 6, 16'h0500);
      chk("rearm_done", done, 1);
      chk("rearm_level", level, 1);
      chk("rearm_head", out_data, 16'h0502);
      out_ready = 1'b1;
      run(7, 9, 16'h0500);
      check_rx("rearm_rx", 16'h0502, 1);

      // Continuous capture of 100 ticks, then reset mid-run
      out_ready = 1'b1;
      do_arm(8'd0, 8'd0);
      busy_bad = 0;
      for (int n = 1; n <= 200; n++) begin
         y_in = 16'h1000 + 16'((n - 1) / 2);
         cyc();
         if (busy !== 1'b1) busy_bad++;
      end
      chk("cont_busy", busy_bad, 0);
      run(201, 201, 16'h1000);
      check_rx("cont_rx", 16'h1000, 100);
      out_ready = 1'b0;
      run(202, 207, 16'h1000);
      chk("cont_level3", level, 3);
      chk("cont_valid", out_valid, 1);
      reset = 1'b0;
      run(208, 208, 16'h1000);
      reset = 1'b1;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      run(209, 212, 16'h1000);
      chk("mid_rst_idle", level, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iir_sample_capture.md
# iir_sample_capture

Output-side capture buffer for the IIR filter datapath. It samples the filter output `y` once per filter sample period, optionally discards a programmed number of settling samples, then stores a programmed number of samples in a first-word-fall-through FIFO. Software or a downstream sink drains the FIFO through a valid/ready port. It is the receive end of the sample stream whose transmit end drives `x` into the filter at the same sample rate.

## Interface

**Parameters**
- `DATA_W`, 16: sample width; matches the filter `y`.
- `DEPTH`, 16: FIFO entries; must be a power of two and at least 2.
- `DIV`, 2: clocks per filter sample period; must be at least 1.

**Ports**
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `y_in`  in  DATA_W: filter output sample.
- `arm`  in  1: start a capture run (one-cycle pulse or level).
- `stop`  in  1: abort a run in progress.
- `skip`  in  8: number of sample ticks discarded before capture.
- `count`  in  8: number of ticks in the capture window; 0 means continuous.
- `out_data`  out  DATA_W: FIFO head; 0 when `out_valid`=0.
- `out_valid`  out  1: FIFO not empty.
- `out_ready`  in  1: sink accepts `out_data`.
- `busy`  out  1: state is SETTLE or CAPTURE.
- `done`  out  1: sticky; set when a counted run completes.
- `overflow`  out  1: sticky; a sample was dropped because the FIFO was full.
- `level`  out  $clog2(DEPTH)+1: current FIFO occupancy.

## Operation

- **FSM states:** IDLE, SETTLE, CAPTURE, DONE.
- **Reset (`reset`=0 at an edge):**
  - State goes to IDLE.
  - Divider, skip and capture counters go to 0.
  - FIFO is emptied; `level`=0.
  - `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `overflow`=0.
  - Reset overrides every other input.
- **Arming:** `arm`=1 in IDLE or DONE has the following effects.
  - Loads the skip and capture counters from `skip` and `count`.
  - Clears the divider, `done` and `overflow`.
  - Next state is SETTLE if `skip`≠0, otherwise CAPTURE.
  - FIFO contents are preserved.
  - `arm` is ignored in SETTLE and CAPTURE.
- **Sample tick:**
  - The divider counts 0…DIV-1 and wraps, only while `busy`=1.
  - `tick`=1 in the cycle where divider = DIV-1.
  - The first tick after arming therefore falls DIV cycles after the arm edge.
- **SETTLE:**
  - Each tick decrements the skip counter; `y_in` is not stored.
  - A tick with skip counter = 1 moves the FSM to CAPTURE.
- **CAPTURE:** each tick offers `y_in` to the FIFO.
  - The write is accepted if `level`<DEPTH, or if a read occurs in the same cycle.
  - Otherwise the sample is dropped and `overflow` is set.
  - With `count`≠0, every tick decrements the capture counter, including dropped ticks.
  - A tick with capture counter = 1 moves the FSM to DONE and sets `done`=1.
  - With `count`=0 the FSM stays in CAPTURE until `stop` or reset.
- **`stop`:** `stop`=1 in SETTLE or CAPTURE returns the FSM to IDLE at the next edge. `done` is not set, and the FIFO keeps its contents. `stop` has no effect in IDLE or DONE.
- **Simultaneous `stop` and tick:** `stop` wins and the sample is not written.
- **Readout:**
  - A transfer occurs when `out_valid`=1 and `out_ready`=1 at an edge.
  - The head advances, and `level` decrements unless a write is accepted in the same cycle.
  - Readout works in every state.
- **FIFO pointers:** binary, wrapping modulo DEPTH.
- **Data path:** no arithmetic on the data; `y_in` is stored bit-exact.

## Timing

- **Write latency:** a sample written at a tick edge is visible on `out_data` with `out_valid`=1 in the cycle after that edge, when the FIFO was empty.
- **`level`:** registered; updated at the same edge as the write or read.
- **`busy`:** rises the cycle after the arm edge and falls the cycle after the DONE or stop transition.
- **`done`:** remains 1 until the next accepted `arm` or reset.
- **`overflow`:** remains 1 until the next accepted `arm` or reset.
- **Full with simultaneous tick and read:** the write is accepted, `level` stays at DEPTH, and `overflow` is unchanged.
- **Empty with simultaneous write:** a read cannot occur (`out_valid`=0); the write is accepted.
- **Reset mid-run:** all state and FIFO contents are cleared in one edge.

## Test plan

1. **Reset priority:** hold `reset`=0 for one cycle with `arm`=1 and `out_ready`=1 → every output is 0 and the FSM stays in IDLE the next cycle.
2. **Counted run:** DIV=2, `skip`=3, `count`=4, `y_in`=0x0100+tick index, `out_ready`=1.
   - Sink receives 0x0103, 0x0104, 0x0105, 0x0106 in order.
   - `done`=1 and `busy`=0 from 14 cycles after the arm edge.
   - `overflow`=0.
3. **Overflow:** `skip`=0, `count`=20, `out_ready`=0.
   - `level` saturates at 16 and `overflow`=1.
   - Draining returns the first 16 samples only.
   - `done`=1 after 20 ticks.
4. **Full with concurrent read:** fill to 16, then assert `out_ready`=1 on a tick cycle → write accepted, `level`=16, `overflow` stays 0, ordering preserved.
5. **Stop mid-capture:** `count`=0; pulse `stop` after 5 captured ticks → IDLE the next cycle, `done`=0, exactly 5 entries readable. A later `arm` is accepted.
6. **Continuous and mid-run reset:** `count`=0, `out_ready`=1 for 100 ticks → all 100 samples arrive in order and `busy` stays 1. Then assert `reset`=0 for one cycle → `level`=0, `busy`=0, `out_valid`=0.
